md5_search_ctrl: RTL and testbench
==================================

Name: md5_search_ctrl

Overview:
Initiator-side controller that drives the md5 core's request/response interface. It issues a sequence of 128-bit candidates (base + index) to the core one at a time and checks each returned digest against a masked target. It stops on the first match, on count exhaustion, on abort, or on response timeout. It sits between a host/CSR block and one md5 core instance, and owns the core's in/in_valid side.

Parameters:
CNT_W, 32, width of candidate count and index counters
TIMEOUT, 255, max cycles waiting for md5_out_valid after an accepted request (>=80)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse, begins a search; ignored unless idle
abort  in  1  one-cycle pulse, stops the search after the in-flight request drains
base  in  128  first candidate, sampled on start
count  in  CNT_W  number of candidates to try, sampled on start
target  in  128  expected digest {A,B,C,D}, sampled on start
mask  in  128  compare mask, 1 = bit compared, sampled on start
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse at end of search
found  out  1  match found, held until next start
found_cand  out  128  matching candidate, valid when found
tried  out  CNT_W  digests checked, held until next start
timeout_err  out  1  core failed to respond within TIMEOUT, held until next start
aborted  out  1  search ended by abort, held until next start
md5_in  out  128  candidate to core
md5_in_valid  out  1  request strobe to core
md5_ready  in  1  core idle/accepting
md5_out  in  128  digest from core
md5_out_valid  in  1  one-cycle digest valid from core

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-search abandons everything. The core is reset by the same rst, so no drain is needed.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, start=1: latch base, count, target, mask; clear found, tried, timeout_err, aborted, found_cand; idx<=0. If count==0, go to DONE; else go to ISSUE.
- ISSUE:
  - md5_in = base + zero-extended idx, full 128-bit add, wraps mod 2^128.
  - md5_in_valid = md5_ready, combinational, asserted only in ISSUE.
  - Acceptance = md5_in_valid & md5_ready at a clock edge. On acceptance: go to WAIT, load timer to 0.
  - Never assert md5_in_valid in any other state.
- WAIT:
  - Timer increments each cycle.
  - On md5_out_valid: tried<=tried+1; idx<=idx+1.
    - Match = ((md5_out ^ target) & mask) == 0.
    - If match: found<=1, found_cand<=candidate, go to DONE.
    - Else if abort was seen during this search, or tried+1==count: go to DONE.
    - Else: go to ISSUE.
  - If timer reaches TIMEOUT with no md5_out_valid: timeout_err<=1, go to DONE.
- Abort:
  - In ISSUE: go to DONE immediately; aborted<=1; no request is issued that cycle.
  - In WAIT: set a sticky abort_pend and finish the in-flight response first. The match check still applies. Then go to DONE with aborted<=1 (unless found).
  - In IDLE/DONE: ignored.
- DONE: done=1 for one cycle, then IDLE. busy is low in IDLE and DONE, high in ISSUE and WAIT.
- start while busy: ignored. start and abort in the same IDLE cycle: start wins, abort dropped.
- mask=0 matches the first digest. tried saturates at count by construction; an idx wrap at 2^CNT_W is unreachable.
- md5_out_valid outside WAIT is ignored. No pipelining: at most one request in flight.

Decomposition:
- Package md5_search_pkg:
  - state encoding (localparams IDLE/ISSUE/WAIT/DONE)
  - digest width 128
  - default TIMEOUT
- Sub-module md5_digest_match: combinational masked 128-bit compare (digest, target, mask -> match). It is reused by later checker blocks.
- Candidate adder and counters stay inline.

Test Plan:
- Bench stub core: latency 67 cycles, digest = {in[63:0], in[127:64]}.
- base=0, count=3, target=all-ones, mask=all-ones -> three requests with md5_in=0,1,2; done pulse; found=0, tried=3, busy low after.
- base=5, count=10, target={64'h7,64'h0}, mask=all-ones -> candidate 7 matches on the 3rd response; found=1, found_cand=7, tried=3, no 4th md5_in_valid.
- count=0 -> done 2 cycles after start, tried=0, md5_in_valid never asserted.
- base=128'hFFFF..FF, count=2 -> md5_in = FFFF..FF then 0 (wrap); tried=2.
- abort 10 cycles into WAIT of first request, count=100 -> the response is still consumed; tried=1, aborted=1, done; no further request.
- Stub never responds, TIMEOUT=255 -> timeout_err=1 and done 256 cycles after acceptance; a new start clears timeout_err and runs normally.

Source files
------------

// File: rtl/md5_search_pkg.sv
// Shared types and constants for the md5 candidate search controller and
// the digest checker blocks built around the md5 core.
package md5_search_pkg;

    localparam int DIGEST_W        = 128;
    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } search_state_t;

endpackage

// File: rtl/md5_digest_match.sv
// Masked digest compare: a 1 in the mask selects a bit that must equal target.
module md5_digest_match
    import md5_search_pkg::*;
#(
    parameter int W = DIGEST_W
) (
    input  logic [W-1:0] i_digest,
    input  logic [W-1:0] i_target,
    input  logic [W-1:0] i_mask,
    output logic         o_match
);

    assign o_match = ~|((i_digest ^ i_target) & i_mask);

endmodule

// File: rtl/md5_search_ctrl.sv
// Walks candidates base..base+count-1 through one md5 core, one request at a
// time, stopping on the first masked digest match, exhaustion, abort or timeout.
module md5_search_ctrl
    import md5_search_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [DIGEST_W-1:0] base,
    input  logic [CNT_W-1:0]    count,
    input  logic [DIGEST_W-1:0] target,
    input  logic [DIGEST_W-1:0] mask,
    output logic                busy,
    output logic                done,
    output logic                found,
    output logic [DIGEST_W-1:0] found_cand,
    output logic [CNT_W-1:0]    tried,
    output logic                timeout_err,
    output logic                aborted,
    output logic [DIGEST_W-1:0] md5_in,
    output logic                md5_in_valid,
    input  logic                md5_ready,
    input  logic [DIGEST_W-1:0] md5_out,
    input  logic                md5_out_valid
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    search_state_t       r_state, w_next;
    logic [DIGEST_W-1:0] r_base, r_target, r_mask, r_found_cand;
    logic [CNT_W-1:0]    r_count, r_idx, r_tried;
    logic [TMR_W-1:0]    r_timer;
    logic                r_abort_pend, r_found, r_timeout_err, r_aborted;

    logic [DIGEST_W-1:0] w_cand;
    logic                w_match, w_rsp, w_tmo, w_last, w_abort_any;

    md5_digest_match #(.W(DIGEST_W)) u_match (
        .i_digest (md5_out),
        .i_target (r_target),
        .i_mask   (r_mask),
        .o_match  (w_match)
    );

    assign w_cand      = r_base + DIGEST_W'(r_idx);
    assign w_rsp       = (r_state == WAIT) && md5_out_valid;
    assign w_tmo       = (r_state == WAIT) && !md5_out_valid && (r_timer == TMR_W'(TIMEOUT));
    assign w_last      = (r_tried + CNT_W'(1)) == r_count;
    assign w_abort_any = r_abort_pend || abort;

    // An abort in ISSUE suppresses the request in that same cycle.
    assign md5_in       = w_cand;
    assign md5_in_valid = (r_state == ISSUE) && md5_ready && !abort;
    assign busy         = (r_state == ISSUE) || (r_state == WAIT);
    assign done         = (r_state == DONE);
    assign found        = r_found;
    assign found_cand   = r_found_cand;
    assign tried        = r_tried;
    assign timeout_err  = r_timeout_err;
    assign aborted      = r_aborted;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (start) w_next = (count == '0) ? DONE : ISSUE;
            ISSUE: begin
                if (abort)          w_next = DONE;
                else if (md5_ready) w_next = WAIT;
            end
            WAIT: begin
                if (w_rsp)      w_next = (w_match || w_abort_any || w_last) ? DONE : ISSUE;
                else if (w_tmo) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_base        <= '0;
            r_target      <= '0;
            r_mask        <= '0;
            r_count       <= '0;
            r_idx         <= '0;
            r_tried       <= '0;
            r_timer       <= '0;
            r_abort_pend  <= 1'b0;
            r_found       <= 1'b0;
            r_found_cand  <= '0;
            r_timeout_err <= 1'b0;
            r_aborted     <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (start) begin
                    r_base        <= base;
                    r_count       <= count;
                    r_target      <= target;
                    r_mask        <= mask;
                    r_idx         <= '0;
                    r_tried       <= '0;
                    r_abort_pend  <= 1'b0;
                    r_found       <= 1'b0;
                    r_found_cand  <= '0;
                    r_timeout_err <= 1'b0;
                    r_aborted     <= 1'b0;
                end
                ISSUE: begin
                    if (abort)             r_aborted <= 1'b1;
                    else if (md5_in_valid) r_timer   <= '0;
                end
                WAIT: begin
                    r_timer <= r_timer + TMR_W'(1);
                    if (abort) r_abort_pend <= 1'b1;
                    // A match on the draining response wins over a pending abort.
                    if (w_rsp) begin
                        r_tried <= r_tried + CNT_W'(1);
                        r_idx   <= r_idx + CNT_W'(1);
                        if (w_match) begin
                            r_found      <= 1'b1;
                            r_found_cand <= w_cand;
                        end else if (w_abort_any) begin
                            r_aborted <= 1'b1;
                        end
                    end else if (w_tmo) begin
                        r_timeout_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md5_search_ctrl.sv
// Scoreboarded bench: a stub md5 core (67-cycle latency, half-swap digest) and
// a candidate-list reference model; monitors pop expectations as the DUT acts.
module tb_md5_search_ctrl;

    localparam int CNT_W = 32;
    localparam int LAT   = 67;

    logic               clk = 1'b0;
    logic               rst, start, abort;
    logic [127:0]       base, target, mask;
    logic [CNT_W-1:0]   count;
    logic               busy, done, found, timeout_err, aborted;
    logic [127:0]       found_cand, md5_in, md5_out;
    logic [CNT_W-1:0]   tried;
    logic               md5_in_valid, md5_ready, md5_out_valid;

    md5_search_ctrl #(.CNT_W(CNT_W), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .base(base), .count(count), .target(target), .mask(mask),
        .busy(busy), .done(done), .found(found), .found_cand(found_cand),
        .tried(tried), .timeout_err(timeout_err), .aborted(aborted),
        .md5_in(md5_in), .md5_in_valid(md5_in_valid), .md5_ready(md5_ready),
        .md5_out(md5_out), .md5_out_valid(md5_out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         found;
        logic [127:0] cand;
        int           tried;
        logic         aborted;
        logic         tmo;
        int           lat_ref;   // 0: from start cycle, 1: from accept cycle, -1: unchecked
        int           lat_lo;
        int           lat_hi;
    } exp_t;

    exp_t         exp_res[$];
    logic [127:0] exp_cand[$];
    int total = 0, bad = 0;
    int cyc = 0, start_cyc = 0, acc_cyc = 0, acc_cnt = 0, done_cnt = 0;
    logic prev_done = 1'b0;
    logic stub_silent = 1'b0;

    function automatic logic [127:0] swap(input logic [127:0] v);
        return {v[63:0], v[127:64]};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Stub core: accepts when ready, answers LAT cycles later with a half-swap.
    int           stub_cnt;
    logic         stub_pend;
    logic [127:0] stub_in;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            stub_pend <= 1'b0; md5_ready <= 1'b1; md5_out_valid <= 1'b0;
            md5_out <= '0; stub_cnt <= 0; stub_in <= '0;
        end else begin
            md5_out_valid <= 1'b0;
            if (stub_pend) begin
                stub_cnt <= stub_cnt - 1;
                if (stub_cnt == 1) begin
                    md5_out_valid <= 1'b1; md5_out <= swap(stub_in);
                    stub_pend <= 1'b0; md5_ready <= 1'b1;
                end
            end else if (md5_in_valid && md5_ready && !stub_silent) begin
                stub_pend <= 1'b1; stub_cnt <= LAT; md5_ready <= 1'b0; stub_in <= md5_in;
            end
        end
    end

    // Request monitor
    always @(negedge clk) begin
        if (!rst && md5_in_valid) begin
            chk("req_while_busy", busy, 1'b1);
            if (md5_ready) begin
                acc_cnt++;
                acc_cyc = cyc;
                if (exp_cand.size() == 0) begin
                    total++; bad++;
                    $display("FAIL stray_req: got md5_in=%0h expected no request", md5_in);
                end else begin
                    chk("md5_in", md5_in, exp_cand.pop_front());
                end
            end
        end
    end

    // Result monitor
    always @(negedge clk) begin
        if (!rst && done) begin
            chk("done_width", prev_done, 1'b0);
            if (exp_res.size() == 0) begin
                total++; bad++;
                $display("FAIL stray_done: got done expected none");
            end else begin
                exp_t e;
                int lat;
                e = exp_res.pop_front();
                chk("found", found, e.found);
                if (e.found) chk("found_cand", found_cand, e.cand);
                chk("tried", tried, e.tried);
                chk("aborted", aborted, e.aborted);
                chk("timeout_err", timeout_err, e.tmo);
                chk("busy_at_done", busy, 1'b0);
                chk("reqs_left", exp_cand.size(), 0);
                if (e.lat_ref >= 0) begin
                    lat = cyc - ((e.lat_ref == 0) ? start_cyc : acc_cyc);
                    total++;
                    if (lat < e.lat_lo || lat > e.lat_hi) begin
                        bad++;
                        $display("FAIL done_latency: got %0d expected %0d..%0d", lat, e.lat_lo, e.lat_hi);
                    end
                end
            end
            done_cnt++;
        end
        prev_done = done;
    end

    // Reference model: the candidate list a search should issue and its outcome.
    // mode 0 normal, 1 abort in first wait, 2 stray start mid-search.
    task automatic model(input logic [127:0] b, input int n, input logic [127:0] t,
                         input logic [127:0] m, input int mode, input logic silent);
        exp_t e;
        e = '{found: 1'b0, cand: '0, tried: 0, aborted: 1'b0, tmo: 1'b0,
              lat_ref: -1, lat_lo: 0, lat_hi: 0};
        if (n == 0) begin
            e.lat_ref = 0; e.lat_lo = 1; e.lat_hi = 2;
        end else if (silent) begin
            exp_cand.push_back(b);
            e.tmo = 1'b1; e.lat_ref = 1; e.lat_lo = 256; e.lat_hi = 257;
        end else begin
            for (int i = 0; i < n; i++) begin
                logic [127:0] c;
                c = b + 128'(i);
                exp_cand.push_back(c);
                e.tried = i + 1;
                if (((swap(c) ^ t) & m) == '0) begin
                    e.found = 1'b1; e.cand = c;
                    break;
                end
                if (mode == 1) begin
                    e.aborted = 1'b1;
                    break;
                end
            end
        end
        exp_res.push_back(e);
    endtask

    task automatic run(input logic [127:0] b, input int n, input logic [127:0] t,
                       input logic [127:0] m, input int mode, input logic silent);
        int n0, a0, budget;
        model(b, n, t, m, mode, silent);
        budget = 500 + (LAT + 10) * ((mode == 1) ? 2 : n + 1);
        stub_silent = silent;
        n0 = done_cnt; a0 = acc_cnt;
        @(negedge clk);
        base = b; count = CNT_W'(n); target = t; mask = m; start = 1'b1; start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        base = rnd128(); count = $urandom; target = rnd128(); mask = rnd128();
        if (n != 0) chk("busy_running", busy, 1'b1);
        if (mode != 0) begin
            for (int k = 0; k < 200 && acc_cnt == a0; k++) @(negedge clk);
            repeat ((mode == 1) ? 10 : 5) @(negedge clk);
            if (mode == 1) abort = 1'b1; else start = 1'b1;
            @(negedge clk);
            abort = 1'b0; start = 1'b0;
        end
        for (int k = 0; k < budget && done_cnt == n0; k++) @(negedge clk);
        if (done_cnt == n0) begin
            total++; bad++;
            $display("FAIL done_wait: got no done expected done within %0d cycles", budget);
            $display("test done: total=%0d bad=%0d", total, bad);
            $fatal(1, "search hung");
        end
        repeat (3) @(negedge clk);
        chk("busy_idle", busy, 1'b0);
        stub_silent = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        base = '0; count = '0; target = '0; mask = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_found", found, 1'b0);
        chk("rst_found_cand", found_cand, '0);
        chk("rst_tried", tried, '0);
        chk("rst_tmo", timeout_err, 1'b0);
        chk("rst_aborted", aborted, 1'b0);
        chk("rst_in_valid", md5_in_valid, 1'b0);

        run(128'd0, 3, {128{1'b1}}, {128{1'b1}}, 0, 1'b0);
        run(128'd5, 10, {64'h7, 64'h0}, {128{1'b1}}, 0, 1'b0);
        run(128'd9, 0, '0, '0, 0, 1'b0);
        run({128{1'b1}}, 2, 128'h1, {128{1'b1}}, 0, 1'b0);
        run(128'd40, 100, {128{1'b1}}, {128{1'b1}}, 1, 1'b0);
        run(128'd77, 4, rnd128(), '0, 0, 1'b0);
        run(128'd3, 5, '0, '0, 0, 1'b1);
        run(128'd3, 2, 128'h5, {128{1'b1}}, 0, 1'b0);
        run(128'd100, 6, {64'h65, 64'h0}, {128{1'b1}}, 2, 1'b0);

        for (int r = 0; r < 8; r++) begin
            logic [127:0] b, t, m;
            int n, h;
            b = rnd128();
            n = $urandom_range(1, 5);
            h = $urandom_range(0, n + 1);
            m = (r % 3 == 0) ? {128{1'b1}} : rnd128();
            t = (h < n) ? (swap(b + 128'(h)) ^ (rnd128() & ~m)) : rnd128();
            run(b, n, t, m, (r == 5) ? 1 : ((r % 2) ? 2 : 0), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
